ysyx_22040759_cache_axi_bridge: RTL and testbench

- Responder end of the icache/dcache valid/ready memory interface driven by the CPU core.
- Arbitrates between one icache read port and one dcache read/write port, and converts each accepted request into a single-beat AXI4 master transaction (len=0, burst INCR).
- Returns read data and a one-cycle ready pulse to the requester.
- Sits between the CPU top and the SoC AXI crossbar.

---
 rtl/ysyx_22040759_cache_axi_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_ysyx_22040759_cache_axi_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_cache_axi_bridge
// Brief    : Arbitrates icache/dcache valid-ready requests onto single-beat
//            AXI4 transactions and returns a one-cycle ready pulse.
//            Define YSYX_22040759_RR_ARB_EN for round-robin arbitration.
// Revision : 1.0
// ============================================================================
module ysyx_22040759_cache_axi_bridge #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter logic [3:0] I_ID   = 4'd0,
  parameter logic [3:0] D_ID   = 4'd1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              icache_valid,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_ready,
  output logic [DATA_W-1:0] icache_data_read,
  input  logic              dcache_valid,
  input  logic              dcache_req,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [2:0]        dcache_size,
  input  logic [DATA_W-1:0] dcache_data_write,
  output logic              dcache_ready,
  output logic [DATA_W-1:0] dcache_data_read,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [3:0]        axi_awid,
  output logic [2:0]        axi_awsize,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [7:0]        axi_wstrb,
  output logic              axi_wlast,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  input  logic [1:0]        axi_bresp,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [3:0]        axi_arid,
  output logic [2:0]        axi_arsize,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_size;
  logic                r_is_wr;
  logic                r_src_d;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_aw_done;
  logic                r_w_done;
  logic                w_prio_d;
  logic                w_grant_d;
  logic                w_any_valid;
  logic                w_aw_fire;
  logic                w_w_fire;
  logic [7:0]          w_lane_mask;
  logic [7:0]          w_strb;
  logic                w_unused;

  // Response/last fields carry nothing the requester can act on.
  assign w_unused = &{1'b0, axi_rresp, axi_rlast, axi_bresp};

`ifdef YSYX_22040759_RR_ARB_EN
  logic r_last_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == RESP) begin
      r_last_d <= r_src_d;
    end
  end

  assign w_prio_d = ~r_last_d;
`else
  assign w_prio_d = 1'b1;
`endif

  assign w_any_valid = icache_valid | dcache_valid;
  assign w_grant_d   = dcache_valid & (~icache_valid | w_prio_d);
  assign w_aw_fire   = ~r_aw_done & axi_awready;
  assign w_w_fire    = ~r_w_done & axi_wready;

  always_comb begin
    case (r_size)
      3'd0:    w_lane_mask = 8'h01;
      3'd1:    w_lane_mask = 8'h03;
      3'd2:    w_lane_mask = 8'h0F;
      default: w_lane_mask = 8'hFF;
    endcase
    w_strb = w_lane_mask << r_addr[2:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr    <= '0;
      r_size    <= '0;
      r_is_wr   <= 1'b0;
      r_src_d   <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any_valid) begin
        r_src_d   <= w_grant_d;
        r_addr    <= w_grant_d ? dcache_addr : icache_addr;
        r_size    <= w_grant_d ? dcache_size : 3'd3;
        r_is_wr   <= w_grant_d & dcache_req;
        r_wdata   <= dcache_data_write;
        r_rdata   <= '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == WR_AWW) begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
      if (r_state == RD_R && axi_rvalid) begin
        r_rdata <= axi_rdata;
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    icache_ready     = 1'b0;
    icache_data_read = '0;
    dcache_ready     = 1'b0;
    dcache_data_read = '0;
    axi_awvalid      = 1'b0;
    axi_awaddr       = '0;
    axi_awid         = '0;
    axi_awsize       = '0;
    axi_wvalid       = 1'b0;
    axi_wdata        = '0;
    axi_wstrb        = '0;
    axi_wlast        = 1'b0;
    axi_bready       = 1'b0;
    axi_arvalid      = 1'b0;
    axi_araddr       = '0;
    axi_arid         = '0;
    axi_arsize       = '0;
    axi_rready       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_next_state = (w_grant_d && dcache_req) ? WR_AWW : RD_AR;
        end
      end
      RD_AR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = r_addr;
        axi_arid    = r_src_d ? D_ID : I_ID;
        axi_arsize  = r_size;
        if (axi_arready) w_next_state = RD_R;
      end
      RD_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) w_next_state = RESP;
      end
      WR_AWW: begin
        // Address and data channels retire independently, in either order.
        axi_awvalid = ~r_aw_done;
        axi_awaddr  = r_aw_done ? '0 : r_addr;
        axi_awid    = r_aw_done ? 4'd0 : D_ID;
        axi_awsize  = r_aw_done ? 3'd0 : r_size;
        axi_wvalid  = ~r_w_done;
        axi_wdata   = r_w_done ? '0 : r_wdata;
        axi_wstrb   = r_w_done ? 8'd0 : w_strb;
        axi_wlast   = ~r_w_done;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
          w_next_state = WR_B;
        end
      end
      WR_B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) w_next_state = RESP;
      end
      RESP: begin
        icache_ready     = ~r_src_d;
        dcache_ready     = r_src_d;
        icache_data_read = r_src_d ? '0 : r_rdata;
        dcache_data_read = (r_src_d && !r_is_wr) ? r_rdata : '0;
        w_next_state     = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040759_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040759_cache_axi_bridge
// Brief    : Randomized self-checking bench with an AXI slave and a
//            transaction-level arbitration/response reference model.
// Revision : 1.0
// ============================================================================
module tb_ysyx_22040759_cache_axi_bridge;
  localparam int         ADDR_W = 32;
  localparam int         DATA_W = 64;
  localparam logic [3:0] I_ID   = 4'd0;
  localparam logic [3:0] D_ID   = 4'd1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic              icache_valid, icache_ready;
  logic [ADDR_W-1:0] icache_addr;
  logic [DATA_W-1:0] icache_data_read;
  logic              dcache_valid, dcache_req, dcache_ready;
  logic [ADDR_W-1:0] dcache_addr;
  logic [2:0]        dcache_size;
  logic [DATA_W-1:0] dcache_data_write, dcache_data_read;
  logic              axi_awvalid, axi_awready;
  logic [ADDR_W-1:0] axi_awaddr;
  logic [3:0]        axi_awid;
  logic [2:0]        axi_awsize;
  logic              axi_wvalid, axi_wready, axi_wlast;
  logic [DATA_W-1:0] axi_wdata;
  logic [7:0]        axi_wstrb;
  logic              axi_bvalid, axi_bready;
  logic [1:0]        axi_bresp;
  logic              axi_arvalid, axi_arready;
  logic [ADDR_W-1:0] axi_araddr;
  logic [3:0]        axi_arid;
  logic [2:0]        axi_arsize;
  logic              axi_rvalid, axi_rready, axi_rlast;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;

  always #5 clock = ~clock;

  ysyx_22040759_cache_axi_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .I_ID(I_ID), .D_ID(D_ID)
  ) dut (
    .clock(clock), .reset(reset),
    .icache_valid(icache_valid), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_data_read(icache_data_read),
    .dcache_valid(dcache_valid), .dcache_req(dcache_req),
    .dcache_addr(dcache_addr), .dcache_size(dcache_size),
    .dcache_data_write(dcache_data_write), .dcache_ready(dcache_ready),
    .dcache_data_read(dcache_data_read),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awsize(axi_awsize),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arid(axi_arid), .axi_arsize(axi_arsize),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
  );

  logic any_out;
  assign any_out = |{icache_ready, icache_data_read, dcache_ready, dcache_data_read,
                     axi_awvalid, axi_awaddr, axi_awid, axi_awsize,
                     axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
                     axi_arvalid, axi_araddr, axi_arid, axi_arsize, axi_rready};

  typedef struct packed { logic [3:0] id; logic [2:0] size; logic [31:0] addr; } a_t;
  typedef struct packed { logic [63:0] data; logic [7:0] strb; logic last; } w_t;
  typedef struct { bit wr; logic [31:0] addr; logic [2:0] size; logic [63:0] wdata; } req_t;

  a_t   ar_q[$], aw_q[$];
  w_t   w_q[$];
  req_t iq[$], dq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last_d = 1'b0;

  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0] rresp_cfg = 2'd0;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit rd_pend, aw_seen, w_seen, b_pend;
  logic [31:0] rd_addr_lat;
  int b_hs = 0, aw_cycles = 0, w_cycles = 0, rready_drops = 0;
  a_t s_a;
  w_t s_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd_fn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h00000013_00100093;
    return {a ^ 32'h5A5A_1234, ~a};
  endfunction

  function automatic logic [7:0] exp_strb(input logic [2:0] size, input logic [2:0] off);
    int n;
    logic [7:0] s;
    n = 1 << size;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      if (b >= int'(off) && b < int'(off) + n) s[b] = 1'b1;
    end
    return s;
  endfunction

  // AXI slave: everything decided at negedge; a handshake is recorded when
  // ready is raised against a valid that cannot drop before the next posedge.
  always @(negedge clock) begin
    if (reset) begin
      axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
      axi_rdata = '0; axi_rresp = '0; axi_rlast = 0; axi_bresp = '0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      rd_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
      ar_q.delete(); aw_q.delete(); w_q.delete();
    end else begin
      axi_rvalid = 0;
      if (rd_pend) begin
        if (!axi_rready) rready_drops++;
        else if (r_cnt >= r_dly) begin
          axi_rvalid = 1; axi_rdata = rd_fn(rd_addr_lat); axi_rresp = rresp_cfg;
          axi_rlast = 1; rd_pend = 0;
        end else r_cnt++;
      end
      axi_arready = 0;
      if (axi_arvalid) begin
        if (ar_cnt >= ar_dly) begin
          axi_arready = 1;
          s_a.id = axi_arid; s_a.size = axi_arsize; s_a.addr = axi_araddr;
          ar_q.push_back(s_a);
          rd_pend = 1; rd_addr_lat = axi_araddr; r_cnt = 0; ar_cnt = 0;
        end else ar_cnt++;
      end
      axi_bvalid = 0;
      if (b_pend) begin
        if (b_cnt >= b_dly && axi_bready) begin
          axi_bvalid = 1; axi_bresp = 2'($urandom); b_pend = 0; b_hs++;
        end else b_cnt++;
      end
      axi_awready = 0;
      if (axi_awvalid) begin
        aw_cycles++;
        if (aw_cnt >= aw_dly) begin
          axi_awready = 1;
          s_a.id = axi_awid; s_a.size = axi_awsize; s_a.addr = axi_awaddr;
          aw_q.push_back(s_a);
          aw_cnt = 0; aw_seen = 1;
        end else aw_cnt++;
      end
      axi_wready = 0;
      if (axi_wvalid) begin
        w_cycles++;
        if (w_cnt >= w_dly) begin
          axi_wready = 1;
          s_w.data = axi_wdata; s_w.strb = axi_wstrb; s_w.last = axi_wlast;
          w_q.push_back(s_w);
          w_cnt = 0; w_seen = 1;
        end else w_cnt++;
      end
      if (aw_seen && w_seen) begin
        aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0;
      end
    end
  end

  task automatic present();
    icache_valid = (iq.size() > 0);
    icache_addr  = (iq.size() > 0) ? iq[0].addr : '0;
    dcache_valid = (dq.size() > 0);
    if (dq.size() > 0) begin
      dcache_req = dq[0].wr; dcache_addr = dq[0].addr;
      dcache_size = dq[0].size; dcache_data_write = dq[0].wdata;
    end else begin
      dcache_req = 0; dcache_addr = '0; dcache_size = '0; dcache_data_write = '0;
    end
  endtask

  task automatic check_i(input req_t r);
    a_t a;
    check("i_rdata", icache_data_read, rd_fn(r.addr));
    if (ar_q.size() == 0) check("i_ar_seen", 64'd0, 64'd1);
    else begin
      a = ar_q.pop_front();
      check("i_araddr", 64'(a.addr), 64'(r.addr));
      check("i_arid", 64'(a.id), 64'(I_ID));
      check("i_arsize", 64'(a.size), 64'd3);
    end
  endtask

  task automatic check_d(input req_t r);
    a_t a;
    w_t w;
    if (r.wr) begin
      check("d_wr_rdata", dcache_data_read, 64'd0);
      if (aw_q.size() == 0 || w_q.size() == 0) check("d_aw_w_seen", 64'd0, 64'd1);
      else begin
        a = aw_q.pop_front();
        w = w_q.pop_front();
        check("d_awaddr", 64'(a.addr), 64'(r.addr));
        check("d_awid", 64'(a.id), 64'(D_ID));
        check("d_awsize", 64'(a.size), 64'(r.size));
        check("d_wdata", w.data, r.wdata);
        check("d_wstrb", 64'(w.strb), 64'(exp_strb(r.size, r.addr[2:0])));
        check("d_wlast", 64'(w.last), 64'd1);
      end
    end else begin
      check("d_rdata", dcache_data_read, rd_fn(r.addr));
      if (ar_q.size() == 0) check("d_ar_seen", 64'd0, 64'd1);
      else begin
        a = ar_q.pop_front();
        check("d_araddr", 64'(a.addr), 64'(r.addr));
        check("d_arid", 64'(a.id), 64'(D_ID));
        check("d_arsize", 64'(a.size), 64'(r.size));
      end
    end
  endtask

  // Called at a negedge: serves every queued request, checking grant order
  // from the arbitration rule and each response against the slave model.
  task automatic run_batch(input int exp_lat, input int budget);
    bit exp_src[$];
    int ni, nd, t, stray;
    bit last, pick_d, first, src;
    req_t r;
    ni = iq.size(); nd = dq.size(); last = model_last_d;
    while (ni > 0 || nd > 0) begin
      if (ni > 0 && nd > 0) begin
`ifdef YSYX_22040759_RR_ARB_EN
        pick_d = ~last;
`else
        pick_d = 1'b1;
`endif
      end else pick_d = (nd > 0);
      exp_src.push_back(pick_d);
      last = pick_d;
      if (pick_d) nd--; else ni--;
    end
    model_last_d = last;
    present();
    t = 0; first = 1;
    while (exp_src.size() > 0 && t < budget) begin
      @(negedge clock);
      t++;
      if (icache_ready || dcache_ready) begin
        check("single_ready", 64'(icache_ready & dcache_ready), 64'd0);
        src = dcache_ready;
        check("grant_order", 64'(src), 64'(exp_src.pop_front()));
        if (first && exp_lat > 0) check("latency", 64'(t), 64'(exp_lat));
        first = 0;
        if (src && dq.size() > 0) begin r = dq.pop_front(); check_d(r); end
        else if (!src && iq.size() > 0) begin r = iq.pop_front(); check_i(r); end
        else check("spurious_ready", 64'd1, 64'd0);
        present();
      end
    end
    check("batch_done", 64'(exp_src.size()), 64'd0);
    iq.delete(); dq.delete(); present();
    stray = 0;
    repeat (3) begin
      @(negedge clock);
      if (icache_ready || dcache_ready) stray++;
    end
    check("no_stray_ready", 64'(stray), 64'd0);
    check("axi_log_drained", 64'(ar_q.size() + aw_q.size() + w_q.size()), 64'd0);
  endtask

  function automatic req_t mk_i(input logic [31:0] a);
    req_t r;
    r.wr = 0; r.addr = a; r.size = 3'd3; r.wdata = '0;
    return r;
  endfunction

  function automatic req_t mk_d(input bit wr, input logic [31:0] a,
                                input logic [2:0] sz, input logic [63:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.size = sz; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rand_d();
    logic [2:0] sz, off;
    sz  = 3'($urandom_range(0, 3));
    off = 3'($urandom_range(0, 7)) & ~(3'((1 << sz) - 1));
    return mk_d(1'($urandom), 32'h8000_0000 | ($urandom & 32'h0000_FFF8) | 32'(off),
                sz, {$urandom, $urandom});
  endfunction

  initial begin
    bit found;
    icache_valid = 0; icache_addr = '0;
    dcache_valid = 0; dcache_req = 0; dcache_addr = '0; dcache_size = '0;
    dcache_data_write = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'(any_out), 64'd0);
    reset = 0;
    @(negedge clock);

    iq.push_back(mk_i(32'h8000_0000));
    run_batch(3, 40);

    dq.push_back(mk_d(1, 32'h8000_1005, 3'd0, 64'hAB << 40));
    run_batch(3, 40);

    aw_dly = 3; aw_cycles = 0; w_cycles = 0; b_hs = 0;
    dq.push_back(mk_d(1, 32'h8000_2008, 3'd3, 64'h1122_3344_5566_7788));
    run_batch(0, 40);
    check("aw_valid_cycles", 64'(aw_cycles), 64'd4);
    check("w_valid_cycles", 64'(w_cycles), 64'd1);
    check("b_handshakes", 64'(b_hs), 64'd1);
    aw_dly = 0;

    iq.push_back(mk_i(32'h8000_0100));
    iq.push_back(mk_i(32'h8000_0108));
    dq.push_back(mk_d(0, 32'h8000_3000, 3'd3, '0));
    dq.push_back(mk_d(1, 32'h8000_3002, 3'd1, 64'h0000_0000_BEEF_0000));
    dq.push_back(mk_d(0, 32'h8000_3004, 3'd2, '0));
    run_batch(0, 80);

    r_dly = 100;
    iq.push_back(mk_i(32'h8000_0040));
    present();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (axi_rready) found = 1;
    end
    check("reached_rd_r", 64'(found), 64'd1);
    reset = 1;
    @(negedge clock);
    check("reset_mid_outputs", 64'(any_out), 64'd0);
    iq.delete(); present(); model_last_d = 0;
    @(negedge clock);
    reset = 0; r_dly = 0;
    iq.push_back(mk_i(32'h8000_0000));
    run_batch(3, 40);

    r_dly = 10; rresp_cfg = 2'd2; rready_drops = 0;
    iq.push_back(mk_i(32'h8000_0200));
    dq.push_back(mk_d(0, 32'h8000_4010, 3'd3, '0));
    run_batch(0, 80);
    check("rready_held", 64'(rready_drops), 64'd0);
    r_dly = 0; rresp_cfg = 2'd0;

    for (int n = 0; n < 40; n++) begin
      int ni, nd;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); rresp_cfg = 2'($urandom);
      ni = $urandom_range(0, 2); nd = $urandom_range(0, 3);
      for (int k = 0; k < ni; k++) iq.push_back(mk_i(32'h8000_0000 | ($urandom & 32'h0000_FFF8)));
      for (int k = 0; k < nd; k++) dq.push_back(rand_d());
      run_batch(0, 200);
    end
    check("rready_never_dropped", 64'(rready_drops), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (%0d checks so far)", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
